// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Widths, state encodings and a word-align helper.
package ifu_pkg;

  localparam int CPU_WIDTH       = 32;
  localparam int IFU_STATE_WIDTH = 2;
  localparam int INST_BYTES      = 4;

  typedef enum logic [IFU_STATE_WIDTH-1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  function automatic logic [CPU_WIDTH-1:0] align_word(
    input logic [CPU_WIDTH-1:0] a
  );
    return {a[CPU_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// Program counter for the fetch unit: register, next-PC select, misalign flag.
// Ports: clk, rst_n, commit, redirect_en, redirect_pc in; pc, misalign out.
module ifu_pc_gen
  import ifu_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 commit,
  input  logic                 redirect_en,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic [CPU_WIDTH-1:0] pc,
  output logic                 misalign
);

  logic [CPU_WIDTH-1:0] pc_q;
  logic [CPU_WIDTH-1:0] pc_d;
  logic                 mis_d;

  // commit is already qualified by the caller (HOLD only).
  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (commit) begin
      if (redirect_en) begin
        pc_d  = align_word(redirect_pc);
        mis_d = |redirect_pc[1:0];
      end else begin
        pc_d = pc_q + CPU_WIDTH'(INST_BYTES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      misalign <= mis_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one imem req/gnt/rvalid transaction per instruction.
// Ports: imem handshake, commit/redirect from retire, ifu_* to decode.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 commit_en,
  input  logic                 redirect_en,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [CPU_WIDTH-1:0] imem_rdata,
  output logic                 ifu_start_en,
  output logic                 ifu_done_en,
  output logic [CPU_WIDTH-1:0] ifu_inst_pc,
  output logic [CPU_WIDTH-1:0] ifu_inst,
  output logic                 ifu_misalign
);

  ifu_state_e           state_q;
  ifu_state_e           state_d;
  logic                 commit_ok;
  logic [CPU_WIDTH-1:0] pc;

  assign commit_ok = (state_q == IFU_HOLD) && commit_en;

  ifu_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .commit      (commit_ok),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .misalign    (ifu_misalign)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE: if (enable)      state_d = IFU_REQ;
      IFU_REQ:  if (imem_gnt)    state_d = IFU_WAIT;
      IFU_WAIT: if (imem_rvalid) state_d = IFU_HOLD;
      IFU_HOLD: begin
        if (commit_en) state_d = enable ? IFU_REQ : IFU_IDLE;
      end
      default:                   state_d = IFU_IDLE;
    endcase
  end

  // Pulses are registered from the transition so they mark
  // the first cycle of the new state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IFU_IDLE;
      ifu_start_en <= 1'b0;
      ifu_done_en  <= 1'b0;
      ifu_inst     <= '0;
      ifu_inst_pc  <= '0;
    end else begin
      state_q      <= state_d;
      ifu_start_en <= (state_d == IFU_REQ) && (state_q != IFU_REQ);
      ifu_done_en  <= (state_d == IFU_HOLD) && (state_q != IFU_HOLD);
      if ((state_q == IFU_WAIT) && imem_rvalid) begin
        ifu_inst    <= imem_rdata;
        ifu_inst_pc <= pc;
      end
    end
  end

  assign imem_req  = (state_q == IFU_REQ);
  assign imem_addr = pc;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: vector table, directed corners,
// then random traffic against a transaction-level reference model.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        commit_en;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifu_start_en;
  logic        ifu_done_en;
  logic [31:0] ifu_inst_pc;
  logic [31:0] ifu_inst;
  logic        ifu_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .commit_en    (commit_en),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .ifu_start_en (ifu_start_en),
    .ifu_done_en  (ifu_done_en),
    .ifu_inst_pc  (ifu_inst_pc),
    .ifu_inst     (ifu_inst),
    .ifu_misalign (ifu_misalign)
  );

  typedef struct {
    logic        en, g, rv, c, re;
    logic [31:0] rpc, rdata;
    logic        x_req, x_st, x_dn, x_mis;
    logic [31:0] x_addr, x_inst, x_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic row(input logic en, g, rv, c, re,
                     input logic [31:0] rpc, rdata,
                     input logic req, st, dn, mis,
                     input logic [31:0] addr, inst, ipc);
    vec_t v;
    v.en = en; v.g = g; v.rv = rv; v.c = c; v.re = re;
    v.rpc = rpc; v.rdata = rdata;
    v.x_req = req; v.x_st = st; v.x_dn = dn; v.x_mis = mis;
    v.x_addr = addr; v.x_inst = inst; v.x_ipc = ipc;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    enable = 0; commit_en = 0; redirect_en = 0;
    redirect_pc = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
  endtask

  // At entry: first cycle of REQ at address addr.
  task automatic fetch(input int gd, input int rd,
                       input logic [31:0] data, input logic [31:0] addr);
    int starts = 0;
    int dones = 0;
    for (int k = 0; k <= gd; k++) begin
      chk("req_stable", {31'b0, imem_req}, 1);
      chk("addr_stable", imem_addr, addr);
      starts += int'(ifu_start_en);
      dones += int'(ifu_done_en);
      imem_gnt = (k == gd);
      tick();
    end
    imem_gnt = 0;
    for (int k = 0; k <= rd; k++) begin
      chk("wait_noreq", {31'b0, imem_req}, 0);
      starts += int'(ifu_start_en);
      dones += int'(ifu_done_en);
      imem_rvalid = (k == rd);
      imem_rdata = (k == rd) ? data : ~data;
      tick();
    end
    imem_rvalid = 0;
    chk("fetch_starts", starts, 1);
    chk("fetch_early_done", dones, 0);
    chk("fetch_done", {31'b0, ifu_done_en}, 1);
    chk("fetch_inst", ifu_inst, data);
    chk("fetch_ipc", ifu_inst_pc, addr);
  endtask

  // Reference model state
  typedef enum int {M_IDLE, M_ASK, M_DATA, M_HELD} mph_e;
  mph_e        m_ph;
  logic [31:0] m_pc, m_inst, m_ipc;
  logic        m_st, m_dn, m_mis;

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pulses", {29'b0, ifu_start_en, ifu_done_en, ifu_misalign}, 0);
    chk("rst_inst", ifu_inst, 0);
    chk("rst_ipc", ifu_inst_pc, 0);
    rst_n = 1;

    //  en g rv c re rpc     rdata          req st dn mis addr  inst          ipc
    row(1,0,0,0,0,32'h0,  32'h0,        0,0,0,0,32'h0,  32'h0,        32'h0);
    row(1,1,0,0,0,32'h0,  32'h0,        1,1,0,0,32'h0,  32'h0,        32'h0);
    row(1,0,1,0,0,32'h0,  32'h13,       0,0,0,0,32'h0,  32'h0,        32'h0);
    row(1,0,0,1,0,32'h0,  32'h0,        0,0,1,0,32'h0,  32'h13,       32'h0);
    row(1,1,0,0,0,32'h0,  32'h0,        1,1,0,0,32'h4,  32'h13,       32'h0);
    row(1,0,1,0,0,32'h0,  32'h00A00093, 0,0,0,0,32'h4,  32'h13,       32'h0);
    row(1,0,0,1,1,32'h102,32'h0,        0,0,1,0,32'h4,  32'h00A00093, 32'h4);
    row(1,1,0,0,0,32'h0,  32'h0,        1,1,0,1,32'h100,32'h00A00093, 32'h4);
    row(1,0,1,0,0,32'h0,  32'h00208133, 0,0,0,0,32'h100,32'h00A00093, 32'h4);
    row(1,0,0,1,0,32'h0,  32'h0,        0,0,1,0,32'h100,32'h00208133, 32'h100);
    row(0,1,0,0,0,32'h0,  32'h0,        1,1,0,0,32'h104,32'h00208133, 32'h100);
    row(0,0,1,0,0,32'h0,  32'hFFF00113, 0,0,0,0,32'h104,32'h00208133, 32'h100);
    row(0,0,0,1,0,32'h0,  32'h0,        0,0,1,0,32'h104,32'hFFF00113, 32'h104);
    row(0,0,0,0,0,32'h0,  32'h0,        0,0,0,0,32'h108,32'hFFF00113, 32'h104);
    row(1,0,0,0,0,32'h0,  32'h0,        0,0,0,0,32'h108,32'hFFF00113, 32'h104);
    row(1,0,0,0,0,32'h0,  32'h0,        1,1,0,0,32'h108,32'hFFF00113, 32'h104);
    row(1,1,0,0,0,32'h0,  32'h0,        1,0,0,0,32'h108,32'hFFF00113, 32'h104);
    row(1,0,0,1,1,32'h40, 32'h0,        0,0,0,0,32'h108,32'hFFF00113, 32'h104);
    row(1,0,1,0,0,32'h0,  32'h13,       0,0,0,0,32'h108,32'hFFF00113, 32'h104);
    row(1,0,0,0,0,32'h0,  32'h0,        0,0,1,0,32'h108,32'h13,       32'h108);
    row(1,1,1,0,0,32'h0,  32'h55,       0,0,0,0,32'h108,32'h13,       32'h108);

    foreach (vecs[i]) begin
      checks++;
      if ({imem_req, ifu_start_en, ifu_done_en, ifu_misalign,
           imem_addr, ifu_inst, ifu_inst_pc} !==
          {vecs[i].x_req, vecs[i].x_st, vecs[i].x_dn, vecs[i].x_mis,
           vecs[i].x_addr, vecs[i].x_inst, vecs[i].x_ipc}) begin
        errors++;
        $display("FAIL vec%0d: got req=%b st=%b dn=%b mis=%b addr=%h inst=%h ipc=%h expected req=%b st=%b dn=%b mis=%b addr=%h inst=%h ipc=%h",
                 i, imem_req, ifu_start_en, ifu_done_en, ifu_misalign,
                 imem_addr, ifu_inst, ifu_inst_pc,
                 vecs[i].x_req, vecs[i].x_st, vecs[i].x_dn, vecs[i].x_mis,
                 vecs[i].x_addr, vecs[i].x_inst, vecs[i].x_ipc);
      end
      enable = vecs[i].en; imem_gnt = vecs[i].g;
      imem_rvalid = vecs[i].rv; commit_en = vecs[i].c;
      redirect_en = vecs[i].re; redirect_pc = vecs[i].rpc;
      imem_rdata = vecs[i].rdata;
      tick();
    end
    idle_inputs();

    // HOLD at 0x108: redirect near top of memory, slow memory.
    enable = 1; commit_en = 1; redirect_en = 1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    commit_en = 0; redirect_en = 0;
    chk("redir_mis0", {31'b0, ifu_misalign}, 0);
    fetch(4, 3, 32'h1111_1111, 32'hFFFF_FFFC);
    commit_en = 1;
    tick();
    commit_en = 0;
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_start", {31'b0, ifu_start_en}, 1);
    fetch(0, 0, 32'h2222_2222, 32'h0);

    // Enable dropped while the transaction is in flight.
    commit_en = 1;
    tick();
    commit_en = 0; enable = 0;
    fetch(1, 2, 32'h3333_3333, 32'h4);
    commit_en = 1;
    tick();
    commit_en = 0;
    for (int k = 0; k < 3; k++) begin
      chk("idle_noreq", {30'b0, imem_req, ifu_start_en}, 0);
      tick();
    end
    chk("idle_addr", imem_addr, 32'h8);
    enable = 1;
    tick();
    chk("reen_req", {30'b0, imem_req, ifu_start_en}, 2'b11);
    chk("reen_addr", imem_addr, 32'h8);
    imem_gnt = 1;
    tick();
    imem_gnt = 0; enable = 0;

    // Reset while waiting for data; late rvalid must be dropped.
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mrst_req", {31'b0, imem_req}, 0);
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_inst", ifu_inst, 0);
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 0;
    tick();
    chk("late_done", {31'b0, ifu_done_en}, 0);
    chk("late_inst", ifu_inst, 0);
    chk("late_ipc", ifu_inst_pc, 0);
    enable = 1;
    tick();
    chk("rst_fetch_addr", imem_addr, 32'h0);
    chk("rst_fetch_start", {31'b0, ifu_start_en}, 1);
    fetch(0, 1, 32'h4444_4444, 32'h0);

    // Random traffic; model starts in the first HOLD cycle.
    m_ph = M_HELD; m_pc = 0; m_inst = 32'h4444_4444; m_ipc = 0;
    m_st = 0; m_dn = 1; m_mis = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++;
      if ({imem_req, ifu_start_en, ifu_done_en, ifu_misalign,
           imem_addr, ifu_inst, ifu_inst_pc} !==
          {m_ph == M_ASK, m_st, m_dn, m_mis, m_pc, m_inst, m_ipc}) begin
        errors++;
        $display("FAIL rand%0d: got req=%b st=%b dn=%b mis=%b addr=%h inst=%h ipc=%h expected req=%b st=%b dn=%b mis=%b addr=%h inst=%h ipc=%h",
                 cyc, imem_req, ifu_start_en, ifu_done_en, ifu_misalign,
                 imem_addr, ifu_inst, ifu_inst_pc,
                 m_ph == M_ASK, m_st, m_dn, m_mis, m_pc, m_inst, m_ipc);
      end
      enable      = ($urandom_range(0, 99) < 85);
      imem_gnt    = ($urandom_range(0, 99) < 40);
      imem_rvalid = ($urandom_range(0, 99) < 40);
      commit_en   = ($urandom_range(0, 99) < 30);
      redirect_en = ($urandom_range(0, 99) < 30);
      imem_rdata  = $urandom;
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2:       redirect_pc = 32'($urandom_range(0, 255));
        default: redirect_pc = $urandom;
      endcase
      m_st = 0; m_dn = 0; m_mis = 0;
      case (m_ph)
        M_IDLE: if (enable) begin m_ph = M_ASK; m_st = 1; end
        M_ASK:  if (imem_gnt) m_ph = M_DATA;
        M_DATA: if (imem_rvalid) begin
          m_ph = M_HELD; m_dn = 1;
          m_inst = imem_rdata; m_ipc = m_pc;
        end
        M_HELD: if (commit_en) begin
          if (redirect_en) begin
            m_pc  = redirect_pc & 32'hFFFF_FFFC;
            m_mis = (redirect_pc % 4) != 0;
          end else begin
            m_pc = m_pc + 32'd4;
          end
          if (enable) begin m_ph = M_ASK; m_st = 1; end
          else m_ph = M_IDLE;
        end
        default: m_ph = M_IDLE;
      endcase
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the rvseed multi-cycle core; sits directly upstream of the decode stage. Holds the program counter, issues one request/grant/response transaction per instruction to instruction memory, and presents the fetched word plus its PC with a one-cycle `ifu_done_en` pulse. It then holds that instruction until the retiring stage signals commit. On commit it advances to PC+4 or to a redirect target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports (`CPU_WIDTH` = 32):
- clk  in  1  core clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  core run enable; gates starting new fetches only.
- commit_en  in  1  one-cycle pulse: the current instruction has retired.
- redirect_en  in  1  qualifies commit_en; next PC is redirect_pc.
- redirect_pc  in  `CPU_WIDTH  branch/jump target.
- imem_req  out  1  fetch request.
- imem_addr  out  `CPU_WIDTH  fetch address, equal to the current PC.
- imem_gnt  in  1  request accepted.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  `CPU_WIDTH  instruction word.
- ifu_start_en  out  1  pulse: a fetch transaction has begun.
- ifu_done_en  out  1  pulse: ifu_inst and ifu_inst_pc are valid.
- ifu_inst_pc  out  `CPU_WIDTH  PC of the delivered instruction.
- ifu_inst  out  `CPU_WIDTH  delivered instruction.
- ifu_misalign  out  1  pulse: the redirect target had redirect_pc[1:0] != 0.

## Operation
- FSM states:
  - IDLE: no fetch in flight.
  - REQ: imem_req=1.
  - WAIT: granted, awaiting data.
  - HOLD: instruction delivered, awaiting commit.
- IDLE -> REQ when enable=1.
- REQ -> WAIT on imem_gnt. imem_req and imem_addr stay stable until grant.
- WAIT -> HOLD on imem_rvalid. At that edge imem_rdata is captured into ifu_inst and PC into ifu_inst_pc.
- HOLD, on commit_en:
  - Next PC = redirect_en ? {redirect_pc[31:2],2'b00} : PC+4. PC+4 wraps modulo 2^32.
  - Go to REQ if enable=1, else IDLE.
- ifu_misalign pulses in the cycle after a commit whose redirect_pc[1:0] != 0. The fetch proceeds from the aligned address.
- commit_en and redirect_en outside HOLD are ignored, with no PC change.
- imem_rvalid outside WAIT is ignored. imem_gnt outside REQ is ignored.
- enable deassertion never aborts a transaction in flight. It only prevents the next REQ.
- ifu_inst and ifu_inst_pc hold their values until the next capture.

## Timing
- Reset values (all synchronous on rst_n=0):
  - state=IDLE, PC=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - ifu_start_en=0, ifu_done_en=0, ifu_misalign=0.
  - ifu_inst=0, ifu_inst_pc=0.
- Reset mid-transaction: return to IDLE. A late rvalid after reset is ignored.
- ifu_start_en is high exactly in the first cycle of each REQ visit.
- ifu_done_en is high exactly in the first cycle of each HOLD visit. ifu_inst and ifu_inst_pc are already valid in that cycle, so the decode stage samples on the same edge.
- Minimum fetch latency, enable rising with gnt and rvalid immediate:
  - cycle 0: IDLE.
  - cycle 1: REQ, start_en, gnt.
  - cycle 2: WAIT, rvalid.
  - cycle 3: HOLD, done_en.
- imem protocol: rvalid arrives no earlier than the cycle after gnt. Grant and response latency are otherwise unbounded.
- commit_en in the same cycle as ifu_done_en is legal. The next REQ follows in the very next cycle.
- Commit to next ifu_start_en is 1 cycle.

## Structure
- Shared define header:
  - `CPU_WIDTH
  - `IFU_STATE_WIDTH (2)
  - IFU state encodings IDLE/REQ/WAIT/HOLD = 0/1/2/3
  - `INST_BYTES (4)
- Sub-module ifu_pc_gen holds:
  - the PC register with reset to RESET_PC;
  - next-PC selection (PC+4 or aligned redirect);
  - misalign detection.
- The top level holds the FSM, the imem handshake and the output registers.

## Test plan
- Reset, enable=1, gnt and rvalid immediate with rdata=32'h0000_0013 -> imem_addr=0. start_en at cycle 1, done_en at cycle 3, ifu_inst=32'h13, ifu_inst_pc=0.
- gnt delayed 4 cycles and rvalid delayed 3 more -> imem_req and imem_addr stable throughout, exactly one start_en and one done_en.
- commit_en with redirect_en=1 and redirect_pc=32'h0000_0102 -> next imem_addr=32'h100, ifu_misalign pulses once. A plain commit afterwards -> imem_addr=32'h104.
- PC=32'hFFFF_FFFC, plain commit -> next imem_addr=0 (wrap). Stray commit_en during WAIT -> no PC change.
- enable dropped during WAIT -> transaction completes with done_en, commit leads to IDLE with no imem_req. Re-enable -> fetch from the advanced PC.
- rst_n=0 during WAIT, then rvalid arrives after reset -> no done_en, ifu_inst=0, next fetch starts from RESET_PC.
